// File: rtl/filter_bank_ctrl_if.sv
// Two-wire bus toward the analog-switch devices.
// The controller is master; the device side (or a bench model) is slave.
interface filter_bank_ctrl_if;
    logic sda_i;
    logic sda_oe;
    logic scl_oe;

    modport master (
        input  sda_i,
        output sda_oe,
        output scl_oe
    );

    modport slave (
        output sda_i,
        input  sda_oe,
        input  scl_oe
    );
endinterface

// File: rtl/filter_bank_ctrl.sv
// Filter bank controller: maps the pulse period to a band and writes
// one-hot switch settings to NUM_DEV analog-switch devices over the bus.
module filter_bank_ctrl #(
    parameter int         NUM_DEV   = 4,
    parameter int         PERIOD_W  = 10,
    parameter int         QTR       = 63,
    parameter logic [6:0] BASE_ADDR = 7'h48,
    parameter int         MAX_RETRY = 2,
    parameter int         RST_CYC   = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] pulse_period,
    input  logic                AD_sample_en,
    filter_bank_ctrl_if.master  bus,
    output logic                rst_asw_n,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CW = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1,
        S_DATA, S_ACK2, S_STOP, S_NEXT
    } state_t;

    // Band code 8 marks an out-of-range period.
    function automatic logic [3:0] band_of(input logic [PERIOD_W-1:0] p);
        logic [31:0] v;
        v = 32'(p);
        unique case (1'b1)
            (v >= 146 && v <= 437): band_of = 4'd0;
            (v >= 87  && v <= 145): band_of = 4'd1;
            (v >= 58  && v <= 86):  band_of = 4'd2;
            (v >= 43  && v <= 57):  band_of = 4'd3;
            (v >= 21  && v <= 42):  band_of = 4'd4;
            (v >= 14  && v <= 20):  band_of = 4'd5;
            (v >= 11  && v <= 13):  band_of = 4'd6;
            (v >= 8   && v <= 10):  band_of = 4'd7;
            default:                band_of = 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [3:0] b, input logic odd);
        if (b[3])     byte_of = 8'h00;
        else if (odd) byte_of = 8'h80 >> b[2:0];
        else          byte_of = 8'h01 << b[2:0];
    endfunction

    // Returns {sda_oe, scl_oe}; SCL is low in the first half of every bit.
    function automatic logic [1:0] lines_of(input state_t s, input logic [1:0] ph,
                                            input logic txb);
        case (s)
            S_START:        lines_of = {ph[1], 1'b0};
            S_ADDR, S_DATA: lines_of = {~txb, ~ph[1]};
            S_ACK1, S_ACK2: lines_of = {1'b0, ~ph[1]};
            S_STOP:         lines_of = {1'b1, ~ph[1]};
            default:        lines_of = 2'b00;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qph_q, qph_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] dev_q, dev_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          fail_q, fail_d;
    logic          nack_q;
    logic [PERIOD_W-1:0] pp_q;
    logic [3:0]    cur_q, cur_d, last_q, seq_q;
    logic          cvld_q, lvld_q, pend_q;
    logic [CW-1:0] rcnt_q;
    logic          rasw_q, done_q, err_q, sda_q, scl_q;

    logic       timed, scl_low, stall, tick, qlast, req;
    logic       start_seq, seq_done, set_err;
    logic [7:0] tx_d;
    logic [1:0] ln_d;

    assign cur_d   = band_of(pp_q);
    assign timed   = state_q inside {S_START, S_ADDR, S_ACK1, S_DATA,
                                     S_ACK2, S_STOP};
    assign scl_low = (state_q inside {S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP})
                     && !qph_q[1];
    assign stall   = AD_sample_en && (qcnt_q == '0) && scl_low;
    assign tick    = timed && !stall && (qcnt_q == QW'(QTR - 1));
    assign qlast   = tick && (qph_q == 2'd3);
    assign req     = rasw_q && cvld_q &&
                     (pend_q || !lvld_q || (cur_q != last_q));

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        qph_d     = qph_q;
        bit_d     = bit_q;
        dev_d     = dev_q;
        retry_d   = retry_q;
        fail_d    = fail_q;
        start_seq = 1'b0;
        seq_done  = 1'b0;
        set_err   = 1'b0;
        if (timed && !stall) begin
            if (tick) begin
                qcnt_d = '0;
                qph_d  = qph_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + QW'(1);
            end
        end
        case (state_q)
            S_IDLE: begin
                qcnt_d = '0;
                qph_d  = 2'd0;
                if (req && !AD_sample_en) begin
                    state_d   = S_START;
                    dev_d     = '0;
                    retry_d   = '0;
                    fail_d    = 1'b0;
                    start_seq = 1'b1;
                end
            end
            S_START: if (qlast) begin
                state_d = S_ADDR;
                bit_d   = 3'd7;
            end
            S_ADDR: if (qlast) begin
                if (bit_q == 3'd0) state_d = S_ACK1;
                else               bit_d   = bit_q - 3'd1;
            end
            S_ACK1: if (qlast) begin
                if (nack_q) begin
                    state_d = S_STOP;
                    fail_d  = 1'b1;
                end else begin
                    state_d = S_DATA;
                    bit_d   = 3'd7;
                end
            end
            S_DATA: if (qlast) begin
                if (bit_q == 3'd0) state_d = S_ACK2;
                else               bit_d   = bit_q - 3'd1;
            end
            S_ACK2: if (qlast) begin
                state_d = S_STOP;
                fail_d  = nack_q;
            end
            S_STOP: if (qlast) state_d = S_NEXT;
            S_NEXT: begin
                qcnt_d = '0;
                qph_d  = 2'd0;
                fail_d = 1'b0;
                if (fail_q && (retry_q != RW'(MAX_RETRY))) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_START;
                end else begin
                    set_err = fail_q;
                    retry_d = '0;
                    if (dev_q == DW'(NUM_DEV - 1)) begin
                        state_d  = S_IDLE;
                        seq_done = 1'b1;
                    end else begin
                        dev_d   = dev_q + DW'(1);
                        state_d = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ADDR) tx_d = {7'(BASE_ADDR + 7'(dev_d)), 1'b0};
        else                   tx_d = byte_of(seq_q, dev_d[0]);
        ln_d = lines_of(state_d, qph_d, tx_d[bit_d]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qph_q   <= 2'd0;
            bit_q   <= 3'd0;
            dev_q   <= '0;
            retry_q <= '0;
            fail_q  <= 1'b0;
            nack_q  <= 1'b0;
            pp_q    <= '0;
            cur_q   <= 4'd8;
            last_q  <= 4'd8;
            seq_q   <= 4'd8;
            cvld_q  <= 1'b0;
            lvld_q  <= 1'b0;
            pend_q  <= 1'b0;
            rcnt_q  <= '0;
            rasw_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sda_q   <= 1'b0;
            scl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qph_q   <= qph_d;
            bit_q   <= bit_d;
            dev_q   <= dev_d;
            retry_q <= retry_d;
            fail_q  <= fail_d;
            pp_q    <= pulse_period;
            cur_q   <= cur_d;
            cvld_q  <= 1'b1;
            done_q  <= seq_done;
            err_q   <= err_q | set_err;
            {sda_q, scl_q} <= ln_d;
            if ((state_q == S_ACK1 || state_q == S_ACK2) &&
                qph_q == 2'd3 && qcnt_q == '0)
                nack_q <= bus.sda_i;
            // Latch the set being written; later changes raise pending.
            if (start_seq) begin
                seq_q  <= cur_q;
                last_q <= cur_q;
                lvld_q <= 1'b1;
                pend_q <= 1'b0;
            end else if (busy && cvld_q && (cur_d != cur_q)) begin
                pend_q <= 1'b1;
            end
            if (!rasw_q) begin
                rcnt_q <= rcnt_q + CW'(1);
                rasw_q <= (rcnt_q == CW'(RST_CYC - 1));
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign rst_asw_n  = rasw_q;
    assign bus.sda_oe = sda_q;
    assign bus.scl_oe = scl_q;

endmodule
